// File: rtl/i2s_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_transmitter
//   Serializes one signed mono sample per frame to a DAC as Philips I2S. The
//   same sample is sent in the left and the right slot. bclk and lrclk are
//   derived from the system clock. When a frame starts and no new sample is
//   held, a one-clock underrun pulse is raised.
//
//   Optional build macro: I2S_UNDERRUN_MUTE_EN
//     defined   -> an underrun frame transmits silence (0)
//     undefined -> an underrun frame repeats the previous frame sample
// -----------------------------------------------------------------------------
module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 24,  // bits per sample, MSB first on the wire
  parameter int SLOT_WIDTH   = 32,  // bclk periods per slot, >= SAMPLE_WIDTH+1
  parameter int BCLK_DIV     = 4    // system clocks per bclk half-period, >= 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] audio_in,
  input  logic                    audio_valid,
  output logic                    audio_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int IDX_W = $clog2(2 * SLOT_WIDTH);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int SEL_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(2 * SLOT_WIDTH - 1);
  localparam logic [IDX_W-1:0] SLOT_LEN   = IDX_W'(SLOT_WIDTH);
  localparam logic [IDX_W-1:0] SAMPLE_LEN = IDX_W'(SAMPLE_WIDTH);

  // Registered state
  logic [DIV_W-1:0]        div_q,      div_d;
  logic                    bclk_q,     bclk_d;
  logic [IDX_W-1:0]        bit_idx_q,  bit_idx_d;
  logic                    lrclk_q,    lrclk_d;
  logic                    sdata_q,    sdata_d;
  logic                    underrun_q, underrun_d;
  logic                    full_q,     full_d;
  logic [SAMPLE_WIDTH-1:0] hold_q,     hold_d;
  logic [SAMPLE_WIDTH-1:0] frame_q,    frame_d;

  // Combinational helpers
  logic                    div_wrap;
  logic                    bclk_fall;
  logic                    frame_load;
  logic [IDX_W-1:0]        slot_pos;
  logic [SEL_W-1:0]        bit_sel;

  // Next-state: divider, bit position, frame load, handshake and serializer
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    div_d      = div_q;
    bclk_d     = bclk_q;
    bit_idx_d  = bit_idx_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    full_d     = full_q;
    hold_d     = hold_q;
    frame_d    = frame_q;
    slot_pos   = '0;
    bit_sel    = '0;

    div_wrap   = (div_q == DIV_LAST);
    bclk_fall  = div_wrap && bclk_q;
    frame_load = bclk_fall && (bit_idx_q == IDX_LAST);

    // bclk toggles each time the divider wraps
    if (div_wrap) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end

    // Frame start: take the held sample, or flag an underrun
    if (frame_load) begin
      if (full_q) begin
        frame_d = hold_q;
        full_d  = 1'b0;
      end else begin
        underrun_d = 1'b1;
`ifdef I2S_UNDERRUN_MUTE_EN
        frame_d    = '0;
`else
        frame_d    = frame_q;
`endif
      end
    end

    // Capture only while empty; ready is still low on a load cycle, so a
    // capture and a load can never collide on the holding register.
    if (audio_valid && !full_q) begin
      full_d = 1'b1;
      hold_d = audio_in;
    end

    // lrclk and sdata change only together with the bclk falling edge
    if (bclk_fall) begin
      bit_idx_d = frame_load ? '0 : bit_idx_q + IDX_W'(1);
      lrclk_d   = (bit_idx_d >= SLOT_LEN);
      slot_pos  = lrclk_d ? (bit_idx_d - SLOT_LEN) : bit_idx_d;
      // Position 0 is the one-bclk I2S delay; positions past the sample pad
      // with zeros. frame_d is used so a freshly loaded sample is in effect.
      if ((slot_pos != '0) && (slot_pos <= SAMPLE_LEN)) begin
        bit_sel = SEL_W'(SAMPLE_WIDTH - int'(slot_pos));
        sdata_d = frame_d[bit_sel];
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the sample registers are reset too, not just the control state:
      // the first frame after reset must carry silence, and a pending sample
      // must be dropped.
      div_q      <= '0;
      bclk_q     <= 1'b0;
      bit_idx_q  <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
      hold_q     <= '0;
      frame_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values
      // from before this edge regardless of statement order.
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      bit_idx_q  <= bit_idx_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      full_q     <= full_d;
      hold_q     <= hold_d;
      frame_q    <= frame_d;
    end
  end

  assign audio_ready = !full_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_transmitter
//   Directed and randomized stimulus for i2s_transmitter (SLOT_WIDTH=32,
//   BCLK_DIV=2). A frame-level reference model tracks the holding register
//   and the per-frame sample; a wire-level I2S receiver decodes each slot and
//   compares it with the expected slot image.
// -----------------------------------------------------------------------------
module tb_i2s_transmitter;

  localparam int SW_S = 24;
  localparam int SW   = 32;
  localparam int DIV  = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [SW_S-1:0] audio_in;
  logic            audio_valid;
  logic            audio_ready;
  logic            bclk;
  logic            lrclk;
  logic            sdata;
  logic            underrun;

  i2s_transmitter #(
    .SAMPLE_WIDTH (SW_S),
    .SLOT_WIDTH   (SW),
    .BCLK_DIV     (DIV)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .audio_in    (audio_in),
    .audio_valid (audio_valid),
    .audio_ready (audio_ready),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .underrun    (underrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and wire decoder, evaluated mid-cycle (negedge)
  // ---------------------------------------------------------------------------
  logic            reset_s = 1'b1;
  logic            valid_s = 1'b0;
  logic [SW_S-1:0] data_s  = '0;
  logic            full_m  = 1'b0;
  logic [SW_S-1:0] hold_m  = '0;
  logic [SW_S-1:0] frame_m = '0;
  logic [SW_S-1:0] exp_q[$];
  logic            prev_bclk = 1'b0, prev_lrclk = 1'b0, prev_sdata = 1'b0;
  logic            frame_start, exp_under, accept;
  logic [SW-1:0]   shreg = '0;
  logic [SW-1:0]   exp_slot;
  logic            lr_last = 1'b0, exp_slot_lr = 1'b0;
  int              pos = 0;
  int              frames_seen = 0;
  int              slots_checked = 0;
  int              cyc = 0;
  int              last_bclk_rise = -1, bclk_period = 0;
  int              last_lr_rise = -1, lr_period = 0, lr_high = 0;

  // Model the effect of the preceding posedge, then decode the wire
  always @(negedge clock) begin
    cyc++;
    if (reset_s) begin
      check("rst_bclk", bclk, 0);
      check("rst_lrclk", lrclk, 0);
      check("rst_sdata", sdata, 0);
      check("rst_underrun", underrun, 0);
      check("rst_ready", audio_ready, 1);
      full_m  = 1'b0;
      hold_m  = '0;
      frame_m = '0;
      exp_q.delete();
      exp_q.push_back('0);
      pos = 0; lr_last = 1'b0; shreg = '0; exp_slot_lr = 1'b0;
    end else begin
      frame_start = prev_lrclk && !lrclk;
      exp_under   = frame_start && !full_m;
      accept      = valid_s && !full_m;
      if (frame_start) begin
        if (full_m) begin
          frame_m = hold_m;
          full_m  = 1'b0;
        end else begin
`ifdef I2S_UNDERRUN_MUTE_EN
          frame_m = '0;
`endif
        end
        exp_q.push_back(frame_m);
        frames_seen++;
      end
      if (accept) begin
        hold_m = data_s;
        full_m = 1'b1;
      end
      check("underrun", underrun, exp_under);
      check("audio_ready", audio_ready, !full_m);
      if (sdata !== prev_sdata) check("sdata_on_bclk_fall", prev_bclk && !bclk, 1);
      if (lrclk !== prev_lrclk) check("lrclk_on_bclk_fall", prev_bclk && !bclk, 1);

      // Receiver: sample on bclk rise; an lrclk change marks slot position 0
      if (!prev_bclk && bclk) begin
        if (lrclk != lr_last) pos = 0;
        lr_last = lrclk;
        shreg   = {shreg[SW-2:0], sdata};
        if (pos == SW - 1) begin
          check("slot_queue_depth", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            exp_slot = '0;
            exp_slot[SW-2 -: SW_S] = exp_q[0];
            check(lr_last ? "right_slot" : "left_slot", shreg, exp_slot);
            check("slot_lr", lr_last, exp_slot_lr);
            if (lr_last) void'(exp_q.pop_front());
          end
          exp_slot_lr = ~exp_slot_lr;
          slots_checked++;
        end
        pos++;
        if (last_bclk_rise >= 0) bclk_period = cyc - last_bclk_rise;
        last_bclk_rise = cyc;
      end
      if (!prev_lrclk && lrclk) begin
        if (last_lr_rise >= 0) lr_period = cyc - last_lr_rise;
        last_lr_rise = cyc;
      end
      if (frame_start && last_lr_rise >= 0) lr_high = cyc - last_lr_rise;
    end
    prev_bclk  = bclk;
    prev_lrclk = lrclk;
    prev_sdata = sdata;
    valid_s    = audio_valid;
    data_s     = audio_in;
    reset_s    = reset;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [SW_S-1:0] d);
    audio_valid = 1'b1;
    audio_in    = d;
    wait_cycles(1);
    audio_valid = 1'b0;
  endtask

  task automatic wait_frame_start();
    int start;
    start = frames_seen;
    for (int i = 0; i < 600 && frames_seen == start; i++) wait_cycles(1);
    check("frame_start_timeout", 32'(frames_seen != start), 1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence followed by randomized frames
  // ---------------------------------------------------------------------------
  initial begin
    reset       = 1'b1;
    audio_valid = 1'b0;
    audio_in    = '0;

    // Reset held three clocks
    wait_cycles(3);
    check("init_bclk", bclk, 0);
    check("init_lrclk", lrclk, 0);
    check("init_sdata", sdata, 0);
    check("init_underrun", underrun, 0);
    check("init_ready", audio_ready, 1);
    reset = 1'b0;

    // A5A5A5 in frame 0 goes out in frame 1
    wait_cycles(5);
    send(24'hA5A5A5);
    wait_frame_start();

    // Extremes of the signed range in consecutive frames
    send(24'h800000);
    wait_frame_start();
    send(24'h7FFFFF);
    wait_frame_start();

    // One sample, then two frames with nothing sent -> underruns
    send(24'hA5A5A5);
    wait_frame_start();
    wait_frame_start();
    wait_frame_start();

    // Clock geometry after steady free run
    check("bclk_period", bclk_period, 2 * DIV);
    check("lrclk_period", lr_period, 4 * DIV * SW);
    check("lrclk_high", lr_high, 2 * DIV * SW);

    // Random samples at random offsets, some frames skipped, extra valids
    for (int f = 0; f < 10; f++) begin
      wait_cycles($urandom_range(2, 240));
      if ($urandom_range(0, 3) != 0) send(SW_S'($urandom));
      if ($urandom_range(0, 1) != 0) send(SW_S'($urandom));
      wait_frame_start();
    end

    // Held valid across a load, then reset with the second sample pending
    wait_frame_start();
    send(24'h111111);
    audio_valid = 1'b1;
    audio_in    = 24'h222222;
    wait_frame_start();
    wait_cycles(3);
    audio_valid = 1'b0;
    wait_cycles(150);
    reset = 1'b1;
    wait_cycles(1);
    check("midrst_bclk", bclk, 0);
    check("midrst_lrclk", lrclk, 0);
    check("midrst_sdata", sdata, 0);
    check("midrst_ready", audio_ready, 1);
    wait_cycles(1);
    reset = 1'b0;

    // Two frames after reset: all silence, pending sample gone
    wait_frame_start();
    wait_frame_start();
    wait_cycles(4);
    check("exp_queue_drained", exp_q.size(), 1);
    check("slots_decoded", 32'(slots_checked >= 40), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
